wb_arbiter_2m: RTL and testbench
================================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter ADDR_W, default 32, Wishbone address width.
REQ-002 Parameter DATA_W, default 128, Wishbone data width.
REQ-003 Parameter SEL_W, default DATA_W/8 (16), byte-select width.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, stalled-strobe cycles before abort (range 2..1023).
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_mN_adr / i_mN_sel / i_mN_we / i_mN_dat  in  ADDR_W / SEL_W / 1 / DATA_W  master N (N=0,1) request fields.
REQ-008 i_mN_cyc, i_mN_stb  in  1  master N cycle and strobe.
REQ-009 o_mN_dat  out  DATA_W  read data to master N.
REQ-010 o_mN_ack, o_mN_err  out  1  master N acknowledge and error.
REQ-011 o_s_adr / o_s_sel / o_s_we / o_s_dat  out  ADDR_W / SEL_W / 1 / DATA_W  slave request fields.
REQ-012 o_s_cyc, o_s_stb  out  1  slave cycle and strobe.
REQ-013 i_s_dat  in  DATA_W  slave read data; i_s_ack, i_s_err  in  1  slave responses.
REQ-014 o_gnt  out  2  one-hot current grant (bit N = master N), 2'b00 when none.

Function
REQ-015 FSM states IDLE, GNT0, GNT1, ABORT; transitions registered on i_clk.
REQ-016 IDLE: only m0 cyc -> GNT0; only m1 cyc -> GNT1; both -> master not granted last (last_gnt); neither -> stay.
REQ-017 Arbitration latency exactly 1 cycle: cyc seen in IDLE at edge k, grant and slave signals driven from cycle k+1.
REQ-018 GNTn: slave request fields, cyc, stb driven from master n; o_mn_ack/o_mn_err = i_s_ack/i_s_err; other master ack/err held 0.
REQ-019 o_m0_dat and o_m1_dat both equal i_s_dat at all times.
REQ-020 Outside GNTn, o_s_cyc and o_s_stb SHALL be 0; o_s_adr/sel/we/dat SHALL be 0.
REQ-021 GNTn exits to IDLE when i_mn_cyc is 0 at the edge; last_gnt <= n; one dead IDLE cycle always separates grants.
REQ-022 Grant never pre-empted; multi-beat/locked transfers held while granted cyc stays high.
REQ-023 Watchdog counter: increments each GNTn cycle with stb=1 and no ack/err; clears on ack, err, stb=0 or state change.
REQ-024 Counter reaching TIMEOUT_CYCLES-1 with no ack/err: o_mn_err=1 for that cycle, next state ABORT.
REQ-025 Ack (or err) in the same cycle as terminal count wins: response passed through, counter cleared, no abort.
REQ-026 ABORT: o_s_cyc/o_s_stb=0, both masters' ack/err=0, o_gnt keeps aborted master bit; exit to IDLE when its cyc is 0, last_gnt <= n.
REQ-027 Slave ack and err in same cycle passed through unmodified.

Reset
REQ-028 While i_rst=1 at an edge: state IDLE, last_gnt=1 (m0 wins first tie), counter 0.
REQ-029 All registered outputs 0 after reset; o_gnt=2'b00, o_s_cyc=0, all ack/err=0.
REQ-030 Reset mid-transfer drops o_s_cyc in the following cycle; no response forwarded.

Configuration
REQ-031 Macro WB_ARB_TIMEOUT_EN: defined -> watchdog and ABORT state present per REQ-023..026.
REQ-032 Undefined -> no counter, ABORT unreachable/absent; grant held indefinitely until master drops cyc; TIMEOUT_CYCLES ignored.

Structure
REQ-033 Package wb_arb_pkg SHALL hold state enum (arb_state_t), grant encoding constants, default widths.
REQ-034 Sub-module wb_arb_watchdog (counter + terminal-count flag) instantiated only under WB_ARB_TIMEOUT_EN.
REQ-035 Datapath muxing combinational from registered state; no registering of data/ack paths.

Verification
REQ-036 m0 single read adr 0x100, slave acks after 3 cycles with i_s_dat=0xF0801003 repeated -> o_gnt=01 one cycle after cyc, o_m0_ack one pulse, o_m0_dat matches, o_m1_ack=0.
REQ-037 m0 and m1 assert cyc same cycle after reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then m1 granted.
REQ-038 Both continuously requesting, 4 transfers each -> grants alternate 01,10,01,10..., no grant back-to-back without idle cycle.
REQ-039 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks on m1 write -> o_m1_err pulses on 8th stalled cycle, o_s_cyc low next cycle, ABORT until m1 cyc low.
REQ-040 Same with ack arriving exactly on terminal cycle -> o_m1_ack=1, o_m1_err=0, no ABORT.
REQ-041 i_rst asserted during GNT0 mid-wait -> next cycle o_s_cyc=0, o_gnt=00; subsequent tie grants m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
// Contents: arb_state_t FSM encoding, one-hot grant constants, default widths.
package wb_arb_pkg;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_SEL_W   = DEF_DATA_W / 8;
    localparam int DEF_TIMEOUT = 64;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1,
        ABORT
    } arb_state_t;
endpackage

// File: rtl/wb_arbiter_2m_if.sv
// wb_arbiter_2m_if: bundle of both master request/response ports and the shared slave port.
// Modports: master = arbiter view (drives o_*, samples i_*); slave = environment view.
interface wb_arbiter_2m_if
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DATA_W / 8
) ();
    logic [ADDR_W-1:0] i_m0_adr, i_m1_adr, o_s_adr;
    logic [SEL_W-1:0]  i_m0_sel, i_m1_sel, o_s_sel;
    logic [DATA_W-1:0] i_m0_dat, i_m1_dat, o_s_dat, i_s_dat, o_m0_dat, o_m1_dat;
    logic              i_m0_we, i_m1_we, o_s_we;
    logic              i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb, o_s_cyc, o_s_stb;
    logic              o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, i_s_ack, i_s_err;
    logic [1:0]        o_gnt;

    modport master (
        input  i_m0_adr, i_m0_sel, i_m0_we, i_m0_dat, i_m0_cyc, i_m0_stb,
        input  i_m1_adr, i_m1_sel, i_m1_we, i_m1_dat, i_m1_cyc, i_m1_stb,
        input  i_s_dat, i_s_ack, i_s_err,
        output o_m0_dat, o_m0_ack, o_m0_err, o_m1_dat, o_m1_ack, o_m1_err,
        output o_s_adr, o_s_sel, o_s_we, o_s_dat, o_s_cyc, o_s_stb, o_gnt
    );

    modport slave (
        output i_m0_adr, i_m0_sel, i_m0_we, i_m0_dat, i_m0_cyc, i_m0_stb,
        output i_m1_adr, i_m1_sel, i_m1_we, i_m1_dat, i_m1_cyc, i_m1_stb,
        output i_s_dat, i_s_ack, i_s_err,
        input  o_m0_dat, o_m0_ack, o_m0_err, o_m1_dat, o_m1_ack, o_m1_err,
        input  o_s_adr, o_s_sel, o_s_we, o_s_dat, o_s_cyc, o_s_stb, o_gnt
    );
endinterface

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts consecutive stalled strobe cycles of the granted master.
// Ports: i_clk, i_rst (sync, active-high); active = a grant state is current;
//        stalled = strobe high with no ack/err; tc = terminal count reached this cycle.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic active,
    input  logic stalled,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Any non-stalled cycle or leaving the grant state restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst || !(active && stalled)) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

    assign tc = active && stalled && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master, one-slave Wishbone arbiter with round-robin tie break.
// Ports: i_clk, i_rst (sync, active-high), bus (wb_arbiter_2m_if.master) carrying
//        both master ports, the slave port and the one-hot o_gnt.
// Macro WB_ARB_TIMEOUT_EN: adds the stalled-strobe watchdog and the ABORT state.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SEL_W          = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input logic            i_clk,
    input logic            i_rst,
    wb_arbiter_2m_if.master bus
);
    arb_state_t        state, nxt;
    logic              last_gnt, own, act, own_cyc, own_stb, tc, we;
    logic [ADDR_W-1:0] adr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..1023");
    end

    assign act = state == GNT0 || state == GNT1;

`ifdef WB_ARB_TIMEOUT_EN
    // ABORT must remember which master it belongs to for o_gnt and last_gnt.
    logic abort_m;

    assign own = state == ABORT ? abort_m : state == GNT1;

    wb_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .active (act),
        .stalled(own_stb && !bus.i_s_ack && !bus.i_s_err),
        .tc     (tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) abort_m <= 1'b0;
        else if (nxt == ABORT && state != ABORT) abort_m <= own;
    end
`else
    assign own = state == GNT1;
    assign tc  = 1'b0;
`endif

    assign own_cyc = own ? bus.i_m1_cyc : bus.i_m0_cyc;
    assign own_stb = own ? bus.i_m1_stb : bus.i_m0_stb;

    // Tie in IDLE goes to the master not served last; every grant returns via IDLE.
    always_comb begin
        nxt = state == IDLE ? (bus.i_m0_cyc && (!bus.i_m1_cyc || last_gnt) ? GNT0 :
                               bus.i_m1_cyc ? GNT1 : IDLE) :
              !own_cyc ? IDLE : tc ? ABORT : state;
        adr = !act ? '0 : own ? bus.i_m1_adr : bus.i_m0_adr;
        sel = !act ? '0 : own ? bus.i_m1_sel : bus.i_m0_sel;
        dat = !act ? '0 : own ? bus.i_m1_dat : bus.i_m0_dat;
        we  = act && (own ? bus.i_m1_we : bus.i_m0_we);
    end

    assign bus.o_s_adr  = adr;
    assign bus.o_s_sel  = sel;
    assign bus.o_s_dat  = dat;
    assign bus.o_s_we   = we;
    assign bus.o_s_cyc  = act && own_cyc;
    assign bus.o_s_stb  = act && own_stb;
    assign bus.o_m0_ack = act && !own && bus.i_s_ack;
    assign bus.o_m1_ack = act && own && bus.i_s_ack;
    // Terminal count folds into err; a same-cycle ack/err keeps tc low.
    assign bus.o_m0_err = act && !own && (bus.i_s_err || tc);
    assign bus.o_m1_err = act && own && (bus.i_s_err || tc);
    assign bus.o_m0_dat = bus.i_s_dat;
    assign bus.o_m1_dat = bus.i_s_dat;
    assign bus.o_gnt    = state == IDLE ? GNT_NONE : own ? GNT_M1 : GNT_M0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= nxt;
            if (state != IDLE && nxt == IDLE) last_gnt <= own;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed self-checking bench for wb_arbiter_2m (TIMEOUT_CYCLES=8).
module tb_wb_arbiter_2m;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [127:0] pat = {4{32'hF0801003}};

    always #5 i_clk = ~i_clk;

    wb_arbiter_2m_if bus ();

    wb_arbiter_2m #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_m0_adr = '0; bus.i_m0_sel = '0; bus.i_m0_we = 1'b0; bus.i_m0_dat = '0;
        bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
        bus.i_m1_adr = '0; bus.i_m1_sel = '0; bus.i_m1_we = 1'b0; bus.i_m1_dat = '0;
        bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0;
        bus.i_s_dat = '0; bus.i_s_ack = 1'b0; bus.i_s_err = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.o_gnt !== 2'b00) begin
            fails++; $display("FAIL reset_gnt: got %b want 00", bus.o_gnt);
        end
        tests++;
        if ({bus.o_s_cyc, bus.o_s_stb} !== 2'b00) begin
            fails++; $display("FAIL reset_cyc: got %b want 00", {bus.o_s_cyc, bus.o_s_stb});
        end
        tests++;
        if ({bus.o_m0_ack, bus.o_m0_err, bus.o_m1_ack, bus.o_m1_err} !== 4'b0000) begin
            fails++; $display("FAIL reset_resp: got %b want 0000",
                              {bus.o_m0_ack, bus.o_m0_err, bus.o_m1_ack, bus.o_m1_err});
        end
        i_rst = 1'b0;
    endtask

    task automatic test_single_read();
        bus.i_m0_adr = 32'h100; bus.i_m0_sel = '1; bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1;
        bus.i_m1_adr = 32'h200;
        #1;
        tests++;
        if (bus.o_s_adr !== 32'h0 || bus.o_s_cyc !== 1'b0) begin
            fails++; $display("FAIL idle_zero: adr %h cyc %b want 0 0", bus.o_s_adr, bus.o_s_cyc);
        end
        tick();
        tests++;
        if (bus.o_gnt !== 2'b01) begin
            fails++; $display("FAIL read_gnt: got %b want 01", bus.o_gnt);
        end
        tests++;
        if (bus.o_s_adr !== 32'h100 || bus.o_s_cyc !== 1'b1 || bus.o_s_stb !== 1'b1 || bus.o_s_sel !== 16'hFFFF) begin
            fails++; $display("FAIL read_fwd: adr %h cyc %b stb %b sel %h want 100 1 1 ffff",
                              bus.o_s_adr, bus.o_s_cyc, bus.o_s_stb, bus.o_s_sel);
        end
        tick();
        tick();
        bus.i_s_ack = 1'b1; bus.i_s_dat = pat;
        #1;
        tests++;
        if (bus.o_m0_ack !== 1'b1 || bus.o_m1_ack !== 1'b0) begin
            fails++; $display("FAIL read_ack: m0 %b m1 %b want 1 0", bus.o_m0_ack, bus.o_m1_ack);
        end
        tests++;
        if (bus.o_m0_dat !== pat || bus.o_m1_dat !== pat) begin
            fails++; $display("FAIL read_dat: m0 %h m1 %h want %h", bus.o_m0_dat, bus.o_m1_dat, pat);
        end
        tick();
        bus.i_s_ack = 1'b0; bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
        #1;
        tests++;
        if (bus.o_m0_ack !== 1'b0) begin
            fails++; $display("FAIL read_pulse: got %b want 0", bus.o_m0_ack);
        end
        tick();
        tests++;
        if (bus.o_gnt !== 2'b00) begin
            fails++; $display("FAIL read_release: got %b want 00", bus.o_gnt);
        end
    endtask

    task automatic test_tie();
        clear_inputs();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        bus.i_m0_adr = 32'h100; bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1;
        bus.i_m1_adr = 32'h200; bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        bus.i_m1_we = 1'b1; bus.i_m1_dat = pat;
        tick();
        tests++;
        if (bus.o_gnt !== 2'b01 || bus.o_s_adr !== 32'h100) begin
            fails++; $display("FAIL tie_first: gnt %b adr %h want 01 100", bus.o_gnt, bus.o_s_adr);
        end
        bus.i_s_ack = 1'b1;
        #1;
        tests++;
        if (bus.o_m0_ack !== 1'b1 || bus.o_m1_ack !== 1'b0) begin
            fails++; $display("FAIL tie_ack: m0 %b m1 %b want 1 0", bus.o_m0_ack, bus.o_m1_ack);
        end
        tick();
        bus.i_s_ack = 1'b0; bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
        #1;
        tests++;
        if (bus.o_gnt !== 2'b01 || bus.o_s_cyc !== 1'b0) begin
            fails++; $display("FAIL tie_drop: gnt %b cyc %b want 01 0", bus.o_gnt, bus.o_s_cyc);
        end
        tick();
        tests++;
        if (bus.o_gnt !== 2'b00) begin
            fails++; $display("FAIL tie_gap: got %b want 00", bus.o_gnt);
        end
        tick();
        tests++;
        if (bus.o_gnt !== 2'b10 || bus.o_s_adr !== 32'h200 || bus.o_s_we !== 1'b1 || bus.o_s_dat !== pat) begin
            fails++; $display("FAIL tie_second: gnt %b adr %h we %b want 10 200 1", bus.o_gnt, bus.o_s_adr, bus.o_s_we);
        end
        bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1;
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            bus.i_s_ack = 1'b1;
            #1;
            tests++;
            if (bus.o_gnt !== exp) begin
                fails++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, bus.o_gnt, exp);
            end
            tests++;
            if ({bus.o_m1_ack, bus.o_m0_ack} !== exp) begin
                fails++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, {bus.o_m1_ack, bus.o_m0_ack}, exp);
            end
            tick();
            bus.i_s_ack = 1'b0;
            if (exp[0]) begin bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0; end
            else begin bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0; end
            #1;
            tests++;
            if (bus.o_gnt !== exp) begin
                fails++; $display("FAIL b2b_hold[%0d]: got %b want %b", i, bus.o_gnt, exp);
            end
            tick();
            bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1;
            bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
            #1;
            tests++;
            if (bus.o_gnt !== 2'b00) begin
                fails++; $display("FAIL b2b_gap[%0d]: got %b want 00", i, bus.o_gnt);
            end
        end
        clear_inputs();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.i_m1_adr = 32'h300; bus.i_m1_we = 1'b1; bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            tests++;
            if (bus.o_m1_err !== (c == 8) || bus.o_m0_err !== 1'b0) begin
                fails++; $display("FAIL to_err[%0d]: m1 %b m0 %b want %b 0", c, bus.o_m1_err, bus.o_m0_err, c == 8);
            end
        end
        tick();
        tests++;
        if (bus.o_s_cyc !== 1'b0 || bus.o_gnt !== 2'b10 || bus.o_m1_err !== 1'b0) begin
            fails++; $display("FAIL to_abort: cyc %b gnt %b err %b want 0 10 0", bus.o_s_cyc, bus.o_gnt, bus.o_m1_err);
        end
        tick();
        tests++;
        if (bus.o_gnt !== 2'b10 || bus.o_s_cyc !== 1'b0) begin
            fails++; $display("FAIL to_abort_hold: gnt %b cyc %b want 10 0", bus.o_gnt, bus.o_s_cyc);
        end
        bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0;
        tick();
        tests++;
        if (bus.o_gnt !== 2'b00) begin
            fails++; $display("FAIL to_exit: got %b want 00", bus.o_gnt);
        end
    endtask

    task automatic test_timeout_ack();
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        for (int c = 1; c <= 8; c++) tick();
        bus.i_s_ack = 1'b1;
        #1;
        tests++;
        if (bus.o_m1_ack !== 1'b1 || bus.o_m1_err !== 1'b0) begin
            fails++; $display("FAIL to_ack: ack %b err %b want 1 0", bus.o_m1_ack, bus.o_m1_err);
        end
        tick();
        bus.i_s_ack = 1'b0;
        #1;
        tests++;
        if (bus.o_gnt !== 2'b10 || bus.o_s_cyc !== 1'b1) begin
            fails++; $display("FAIL to_no_abort: gnt %b cyc %b want 10 1", bus.o_gnt, bus.o_s_cyc);
        end
        clear_inputs();
        tick();
        tick();
    endtask
`else
    task automatic test_no_timeout();
        logic saw_err = 1'b0;
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            saw_err = saw_err | bus.o_m1_err;
        end
        tests++;
        if (saw_err !== 1'b0) begin
            fails++; $display("FAIL no_to_err: got %b want 0", saw_err);
        end
        tests++;
        if (bus.o_gnt !== 2'b10 || bus.o_s_cyc !== 1'b1) begin
            fails++; $display("FAIL no_to_hold: gnt %b cyc %b want 10 1", bus.o_gnt, bus.o_s_cyc);
        end
        clear_inputs();
        tick();
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.o_gnt !== 2'b01) begin
            fails++; $display("FAIL rst_pre: got %b want 01", bus.o_gnt);
        end
        i_rst = 1'b1;
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        tick();
        bus.i_s_ack = 1'b1;
        #1;
        tests++;
        if (bus.o_s_cyc !== 1'b0 || bus.o_gnt !== 2'b00 || bus.o_m0_ack !== 1'b0) begin
            fails++; $display("FAIL rst_mid: cyc %b gnt %b ack %b want 0 00 0", bus.o_s_cyc, bus.o_gnt, bus.o_m0_ack);
        end
        i_rst = 1'b0;
        bus.i_s_ack = 1'b0;
        tick();
        tests++;
        if (bus.o_gnt !== 2'b01) begin
            fails++; $display("FAIL rst_tie: got %b want 01", bus.o_gnt);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_ack();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: run did not finish within 100000 time units");
        $fatal(1);
    end
endmodule
